// File: rtl/bus_proto_pkg.sv
// Shared types and protocol constants for the dValid/dAck byte bus.
// Used by the master arbiter and the bus protocol checkers.
package bus_proto_pkg;

  typedef enum logic [1:0] {
    IDLE,
    VALID,
    GAP
  } bus_state_t;

  localparam int DATA_W    = 8;
  localparam int MIN_VALID = 2;
  localparam int MAX_VALID = 4;

  function automatic int cnt_width(input int max_valid);
    return $clog2(max_valid + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit scanning from ptr.
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] win,
  output logic             any
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    any   = |req;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_master_arbiter.sv
// Round-robin master for the dValid/dAck bus; N_REQ local requesters.
// Define BUS_ARB_TIMEOUT_EN to drop transfers not acked by MAX_VALID.
module bus_master_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = bus_proto_pkg::DATA_W,
  parameter int MIN_VALID = bus_proto_pkg::MIN_VALID,
  parameter int MAX_VALID = bus_proto_pkg::MAX_VALID
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    dValid,
  output logic [DATA_W-1:0]       data,
  input  logic                    dAck,
  output logic                    busy,
  output logic                    err
);

  import bus_proto_pkg::*;

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = cnt_width(MAX_VALID);
  localparam logic [CW-1:0] CNT_MIN = CW'(MIN_VALID);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_VALID);

  bus_state_t        state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     widx;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     nxt_ptr;
  logic [CW-1:0]     cnt;
  logic [N_REQ-1:0]  win;
  logic [N_REQ-1:0]  widx_oh;
  logic              any;
  logic [DATA_W-1:0] win_data;
  logic              ack_ok;
  logic              tmo;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .PW   (PW)
  ) u_rr (
    .req(req),
    .ptr(ptr),
    .win(win),
    .any(any)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) win_idx = PW'(i);
    end
  end

  assign win_data = req_data[win_idx*DATA_W +: DATA_W];
  assign widx_oh  = N_REQ'(1) << widx;
  assign nxt_ptr  = (widx == PW'(N_REQ - 1)) ? '0 : widx + 1'b1;
  assign ack_ok   = dAck && (cnt >= CNT_MIN);

`ifdef BUS_ARB_TIMEOUT_EN
  assign tmo = !dAck && (cnt == CNT_MAX);
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      dValid <= 1'b0;
      data   <= '0;
      gnt    <= '0;
      busy   <= 1'b0;
      err    <= 1'b0;
      ptr    <= '0;
      widx   <= '0;
      cnt    <= '0;
    end else begin
      gnt <= '0;
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            state  <= VALID;
            dValid <= 1'b1;
            data   <= win_data;
            widx   <= win_idx;
            cnt    <= CW'(1);
            busy   <= 1'b1;
          end
        end
        VALID: begin
          if (ack_ok) begin
            state  <= GAP;
            dValid <= 1'b0;
            gnt    <= widx_oh;
            ptr    <= nxt_ptr;
          end else if (tmo) begin
            // dropped transfer: no grant, but move past the stuck requester
            state  <= GAP;
            dValid <= 1'b0;
            err    <= 1'b1;
            ptr    <= nxt_ptr;
          end else begin
            err <= dAck;
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          dValid <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
